// File: rtl/apb_master_bridge_pkg.sv
// ----------------------------------------------------------------------------
// apb_master_bridge_pkg
//   Shared types for the single-outstanding APB initiator.
//   - apb_mst_state_e : FSM state encoding (IDLE / SETUP / ACCESS)
//   - ST_*            : the same encodings as plain logic constants, so the
//                       FSM register can be a plain logic vector
//   - apb_mst_rsp_t   : one completed-transfer response {rdata, err}
//   Optional feature macro used by the bridge: APB_MASTER_TIMEOUT_EN.
// ----------------------------------------------------------------------------
package apb_master_bridge_pkg;

   localparam int APB_MST_RSP_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_mst_state_e;

   localparam logic [1:0] ST_IDLE   = IDLE;
   localparam logic [1:0] ST_SETUP  = SETUP;
   localparam logic [1:0] ST_ACCESS = ACCESS;

   typedef struct packed {
      logic [APB_MST_RSP_DATA_WIDTH-1:0] rdata;
      logic                              err;
   } apb_mst_rsp_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// ----------------------------------------------------------------------------
// apb_master_bridge_if
//   Bundles the core-side req/gnt/r_valid bus and the APB initiator bus of
//   the bridge.
//   modport master : the bridge's view (drives gnt, response and APB request)
//   modport slave  : the environment's view (core + APB target)
//   Core side : req_i, gnt_o, addr_i, we_i, wdata_i, r_valid_o, r_rdata_o,
//               r_err_o
//   APB side  : PADDR_o, PWDATA_o, PWRITE_o, PSEL_o, PENABLE_o, PRDATA_i,
//               PREADY_i, PSLVERR_i
//   Handshake: a core transfer is accepted in the cycle where req_i and gnt_o
//   are both high; addr/we/wdata must be held with req_i until then. The
//   response is a single-cycle r_valid_o pulse; there is no back-pressure.
// ----------------------------------------------------------------------------
interface apb_master_bridge_if #(
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32
);
   logic                      req_i;
   logic                      gnt_o;
   logic [APB_ADDR_WIDTH-1:0] addr_i;
   logic                      we_i;
   logic [APB_DATA_WIDTH-1:0] wdata_i;
   logic                      r_valid_o;
   logic [APB_DATA_WIDTH-1:0] r_rdata_o;
   logic                      r_err_o;

   logic [APB_ADDR_WIDTH-1:0] PADDR_o;
   logic [APB_DATA_WIDTH-1:0] PWDATA_o;
   logic                      PWRITE_o;
   logic                      PSEL_o;
   logic                      PENABLE_o;
   logic [APB_DATA_WIDTH-1:0] PRDATA_i;
   logic                      PREADY_i;
   logic                      PSLVERR_i;

   modport master (
      input  req_i, addr_i, we_i, wdata_i, PRDATA_i, PREADY_i, PSLVERR_i,
      output gnt_o, r_valid_o, r_rdata_o, r_err_o,
             PADDR_o, PWDATA_o, PWRITE_o, PSEL_o, PENABLE_o
   );

   modport slave (
      output req_i, addr_i, we_i, wdata_i, PRDATA_i, PREADY_i, PSLVERR_i,
      input  gnt_o, r_valid_o, r_rdata_o, r_err_o,
             PADDR_o, PWDATA_o, PWRITE_o, PSEL_o, PENABLE_o
   );
endinterface

// File: rtl/apb_master_bridge.sv
// ----------------------------------------------------------------------------
// apb_master_bridge
//   Single-outstanding APB initiator: turns a req/gnt + r_valid core bus into
//   APB SETUP/ACCESS transfers. One transfer in flight; all APB outputs and
//   the response are registered, only gnt_o is combinational.
// Ports
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous reset, active-high
//   bus     : apb_master_bridge_if.master (core side + APB side)
//   state_o : current FSM state (ST_IDLE / ST_SETUP / ST_ACCESS), debug only
// Configuration
//   APB_MASTER_TIMEOUT_EN : when defined, an ACCESS phase that sees no
//   PREADY_i for TIMEOUT_CYCLES cycles is aborted with r_err_o=1,
//   r_rdata_o=0. When undefined, ACCESS waits for PREADY_i indefinitely.
// Latency: grant at T, SETUP at T+1, ACCESS at T+2, r_valid_o at T+3 with no
//   wait states; each wait state adds one cycle.
// ----------------------------------------------------------------------------
module apb_master_bridge
   import apb_master_bridge_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   apb_master_bridge_if.master        bus,
   output logic [1:0]                 state_o
);

   // A zero-cycle timeout would abort before the target can ever answer.
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("apb_master_bridge: TIMEOUT_CYCLES must be at least 1");
   end

   logic [1:0]                state_q;
   logic [APB_ADDR_WIDTH-1:0] paddr_q;
   logic [APB_DATA_WIDTH-1:0] pwdata_q;
   logic                      pwrite_q;
   logic                      psel_q;
   logic                      penable_q;
   logic                      r_valid_q;
   logic [APB_DATA_WIDTH-1:0] r_rdata_q;
   logic                      r_err_q;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt_q;
   logic             timeout_hit;

   // Expiry is the cycle whose PREADY_i=0 would push the count to the limit.
   assign timeout_hit = (wait_cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES);
`endif

   // Accepting only in IDLE is what keeps a single transfer in flight; the
   // grant may coincide with the previous r_valid_o pulse.
   assign bus.gnt_o = bus.req_i & (state_q == ST_IDLE);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         paddr_q    <= '0;
         pwdata_q   <= '0;
         pwrite_q   <= 1'b0;
         psel_q     <= 1'b0;
         penable_q  <= 1'b0;
         r_valid_q  <= 1'b0;
         r_rdata_q  <= '0;
         r_err_q    <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
         wait_cnt_q <= '0;
`endif
      end else begin
         r_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.req_i) begin
                  paddr_q  <= bus.addr_i;
                  pwrite_q <= bus.we_i;
                  pwdata_q <= bus.wdata_i;
                  psel_q   <= 1'b1;
                  state_q  <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               penable_q  <= 1'b1;
               state_q    <= ST_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
               wait_cnt_q <= '0;
`endif
            end
            ST_ACCESS: begin
               // PREADY_i wins over a simultaneous timeout expiry.
               if (bus.PREADY_i) begin
                  r_valid_q <= 1'b1;
                  r_rdata_q <= pwrite_q ? '0 : bus.PRDATA_i;
                  r_err_q   <= bus.PSLVERR_i;
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
                  state_q   <= ST_IDLE;
               end
`ifdef APB_MASTER_TIMEOUT_EN
               else if (timeout_hit) begin
                  r_valid_q <= 1'b1;
                  r_rdata_q <= '0;
                  r_err_q   <= 1'b1;
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
                  state_q   <= ST_IDLE;
               end else begin
                  wait_cnt_q <= wait_cnt_q + CNT_W'(1);
               end
`endif
            end
            default: begin
               psel_q    <= 1'b0;
               penable_q <= 1'b0;
               state_q   <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.PADDR_o   = paddr_q;
   assign bus.PWDATA_o  = pwdata_q;
   assign bus.PWRITE_o  = pwrite_q;
   assign bus.PSEL_o    = psel_q;
   assign bus.PENABLE_o = penable_q;
   assign bus.r_valid_o = r_valid_q;
   assign bus.r_rdata_o = r_rdata_q;
   assign bus.r_err_o   = r_err_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// ----------------------------------------------------------------------------
// tb_apb_master_bridge
//   Directed bench for apb_master_bridge. A driver issues core requests and
//   pushes the hand-computed response and completion cycle into queues; a
//   monitor pops and compares on every r_valid_o pulse. A small APB target
//   model answers with a programmed number of wait states and checks that
//   the APB request stays stable while PSEL_o is high.
// ----------------------------------------------------------------------------
module tb_apb_master_bridge;
   import apb_master_bridge_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
`ifdef APB_MASTER_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 255;
`endif
   localparam int RW = $bits(apb_mst_rsp_t);

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] state_o;

   apb_master_bridge_if #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) bus ();

   apb_master_bridge #(
      .APB_ADDR_WIDTH(AW),
      .APB_DATA_WIDTH(DW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .bus     (bus.master),
      .state_o (state_o)
   );

   // ---------------- clock / reset / cycle count ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   logic [RW-1:0] exp_q[$];
   int            exp_cyc_q[$];

   logic [AW-1:0] exp_addr;
   logic          exp_write;
   logic [DW-1:0] exp_wdata;
   int            slv_waits = 0;
   logic [DW-1:0] slv_rdata = '0;
   logic          slv_err = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- APB target model + request stability ----------------
   int  acc_cnt = 0;
   int  setup_cnt = 0;
   logic ready;
   always @(negedge clk) begin
      if (!rst && bus.PSEL_o) begin
         check("paddr_stable",  64'(bus.PADDR_o),  64'(exp_addr));
         check("pwrite_stable", 64'(bus.PWRITE_o), 64'(exp_write));
         check("pwdata_stable", 64'(bus.PWDATA_o), 64'(exp_wdata));
         if (!bus.PENABLE_o) setup_cnt++;
         else if (acc_cnt == 0) check("setup_len", 64'(setup_cnt), 64'd1);
      end else begin
         setup_cnt = 0;
      end
      // Outside ACCESS the target drives noise that the bridge must ignore.
      if (bus.PSEL_o && bus.PENABLE_o) begin
         ready         = (acc_cnt == slv_waits);
         bus.PREADY_i  = ready;
         bus.PRDATA_i  = ready ? slv_rdata : 32'hBAD0_BAD0;
         bus.PSLVERR_i = ready ? slv_err : 1'b1;
         acc_cnt++;
      end else begin
         bus.PREADY_i  = 1'b1;
         bus.PRDATA_i  = 32'hBAD0_BAD0;
         bus.PSLVERR_i = 1'b1;
         acc_cnt       = 0;
      end
   end

   // ---------------- response monitor ----------------
   apb_mst_rsp_t mon_rsp;
   int           mon_cyc;
   always @(negedge clk) begin
      if (bus.r_valid_o) begin
         if (exp_q.size() == 0) begin
            check("unexpected_r_valid", 64'd1, 64'd0);
         end else begin
            mon_rsp = exp_q.pop_front();
            mon_cyc = exp_cyc_q.pop_front();
            check("r_rdata",   64'(bus.r_rdata_o), 64'(mon_rsp.rdata));
            check("r_err",     64'(bus.r_err_o),   64'(mon_rsp.err));
            check("r_latency", 64'(cyc),           64'(mon_cyc));
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at a negedge; returns at the negedge after the grant with req_i
   // still high so the caller decides whether to chain another request.
   task automatic issue(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                        input int waits, input logic [DW-1:0] rd, input logic e,
                        input int lat, input logic [DW-1:0] x_rd, input logic x_e,
                        output int gcyc);
      apb_mst_rsp_t rsp;
      int n = 0;
      bus.req_i   = 1'b1;
      bus.addr_i  = a;
      bus.we_i    = w;
      bus.wdata_i = d;
      #1;
      while (!bus.gnt_o && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!bus.gnt_o) begin
         check("grant_timeout", 64'd0, 64'd1);
         gcyc = -1;
      end else begin
         slv_waits = waits;
         slv_rdata = rd;
         slv_err   = e;
         exp_addr  = a;
         exp_write = w;
         exp_wdata = d;
         rsp.rdata = x_rd;
         rsp.err   = x_e;
         exp_q.push_back(rsp);
         exp_cyc_q.push_back(cyc + lat);
         gcyc = cyc;
      end
      @(negedge clk);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || state_o != ST_IDLE) && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
      @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   int g1, g2, g3;
   initial begin
      rst         = 1'b1;
      bus.req_i   = 1'b0;
      bus.addr_i  = '0;
      bus.we_i    = 1'b0;
      bus.wdata_i = '0;
      repeat (2) @(negedge clk);

      check("rst_psel",    64'(bus.PSEL_o),    64'd0);
      check("rst_penable", 64'(bus.PENABLE_o), 64'd0);
      check("rst_pwrite",  64'(bus.PWRITE_o),  64'd0);
      check("rst_paddr",   64'(bus.PADDR_o),   64'd0);
      check("rst_pwdata",  64'(bus.PWDATA_o),  64'd0);
      check("rst_r_valid", 64'(bus.r_valid_o), 64'd0);
      check("rst_r_rdata", 64'(bus.r_rdata_o), 64'd0);
      check("rst_r_err",   64'(bus.r_err_o),   64'd0);
      check("rst_state",   64'(state_o),       64'(ST_IDLE));
      rst = 1'b0;
      @(negedge clk);

      // Write, no wait states: response at T+3, rdata forced to 0.
      issue(32'h1A10_0004, 1'b1, 32'hDEAD_BEEF, 0, 32'h5555_AAAA, 1'b0, 3, 32'h0, 1'b0, g1);
      bus.req_i = 1'b0;
      wait_idle();

      // Read, 3 wait states: response at T+6.
      issue(32'h1A10_0008, 1'b0, 32'h0000_0000, 3, 32'h1234_5678, 1'b0, 6, 32'h1234_5678, 1'b0, g1);
      bus.req_i = 1'b0;
      wait_idle();
      repeat (2) @(negedge clk);
      check("r_rdata_hold", 64'(bus.r_rdata_o), 64'h1234_5678);

      // Slave error, then a clean read clears r_err.
      issue(32'h1A10_0010, 1'b0, 32'h0, 0, 32'hCAFE_F00D, 1'b1, 3, 32'hCAFE_F00D, 1'b1, g1);
      bus.req_i = 1'b0;
      wait_idle();
      check("r_err_hold", 64'(bus.r_err_o), 64'd1);
      issue(32'h1A10_0014, 1'b0, 32'h0, 1, 32'h0000_00A5, 1'b0, 4, 32'h0000_00A5, 1'b0, g1);
      bus.req_i = 1'b0;
      wait_idle();

      // Back-to-back writes with req_i held: one grant every 3 cycles.
      issue(32'h0000_0100, 1'b1, 32'h0000_0011, 0, 32'h0, 1'b0, 3, 32'h0, 1'b0, g1);
      issue(32'h0000_0104, 1'b1, 32'h0000_0022, 0, 32'h0, 1'b0, 3, 32'h0, 1'b0, g2);
      issue(32'h0000_0108, 1'b1, 32'h0000_0033, 0, 32'h0, 1'b0, 3, 32'h0, 1'b0, g3);
      bus.req_i = 1'b0;
      check("b2b_gap_1", 64'(g2 - g1), 64'd3);
      check("b2b_gap_2", 64'(g3 - g2), 64'd3);
      wait_idle();

      // Reset in the middle of ACCESS: bus drops at once, no response.
      issue(32'h0000_0200, 1'b0, 32'h0, 5, 32'h7777_7777, 1'b0, 8, 32'h7777_7777, 1'b0, g1);
      bus.req_i = 1'b0;
      for (int i = 0; i < 4 && !bus.PENABLE_o; i++) @(negedge clk);
      check("mid_penable_seen", 64'(bus.PENABLE_o), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_psel",    64'(bus.PSEL_o),    64'd0);
      check("mid_rst_penable", 64'(bus.PENABLE_o), 64'd0);
      check("mid_rst_r_valid", 64'(bus.r_valid_o), 64'd0);
      check("mid_rst_state",   64'(state_o),       64'(ST_IDLE));
      exp_q.delete();
      exp_cyc_q.delete();
      @(negedge clk);
      #2;
      rst = 1'b0;
      repeat (10) @(negedge clk);
      issue(32'h0000_0300, 1'b1, 32'hA5A5_5A5A, 2, 32'h0, 1'b0, 5, 32'h0, 1'b0, g1);
      bus.req_i = 1'b0;
      wait_idle();

`ifdef APB_MASTER_TIMEOUT_EN
      // Target never ready: abort after TO ACCESS cycles.
      issue(32'h0000_0400, 1'b0, 32'h0, 1000, 32'hFFFF_FFFF, 1'b0, 2 + TO, 32'h0, 1'b1, g1);
      bus.req_i = 1'b0;
      wait_idle();
      // Ready on the expiry cycle itself is a normal completion.
      issue(32'h0000_0404, 1'b0, 32'h0, TO - 1, 32'h0BAD_F00D, 1'b0, 2 + TO, 32'h0BAD_F00D, 1'b0, g1);
      bus.req_i = 1'b0;
      wait_idle();
`endif

      repeat (5) @(negedge clk);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
